rv_decode_stage: RTL
====================

// Module: rv_decode_stage
// PURPOSE
//  Registered RV32I/RV64I instruction-decode pipeline stage between fetch and execute.
//  - Accepts {pc, inst} over a valid/ready handshake.
//  - Produces a fully decoded bundle: fields, sign-extended immediate, register-use flags and an illegal flag.
//  - Adds buffering, flush, full immediate generation for I/S/B/U/J/shift, and illegal-opcode detection.
// PARAMETERS
//  XLEN     32  datapath/immediate width; legal values 32 or 64.
//  PC_W     32  width of the pc field carried alongside the instruction.
//  SKID     1   0 = single output register, in_ready combinational; 1 = 2-entry skid buffer, in_ready registered.
// PORTS
//  clk        in   1      stage clock, rising edge.
//  rst_n      in   1      asynchronous, active-low reset.
//  flush      in   1      discard all held and incoming instructions.
//  in_valid   in   1      fetch presents an instruction.
//  in_ready   out  1      stage accepts this cycle.
//  in_pc      in   PC_W   pc of in_inst.
//  in_inst    in   32     raw instruction word.
//  out_valid  out  1      decoded bundle valid.
//  out_ready  in   1      execute consumes this cycle.
//  out_pc     out  PC_W   pc of the decoded instruction.
//  out_op     out  7      opcode inst[6:0].
//  out_rd     out  5      destination register; 0 when !out_wr_rd.
//  out_rs1    out  5      source 1; 0 when !out_use_rs1.
//  out_rs2    out  5      source 2; 0 when !out_use_rs2.
//  out_funct3 out  3      inst[14:12]; 0 for U/J types.
//  out_funct7 out  7      inst[31:25] for R-type and shift-immediate; 0 otherwise.
//  out_imm    out  XLEN   immediate, sign-extended to XLEN.
//  out_use_rs1 / out_use_rs2 / out_wr_rd  out  1 each  register-use flags.
//  out_illegal out 1      instruction is not a legal RV32I base encoding.
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0; every out_* data field=0; in_ready=1 (SKID=1).
//  Handshakes:
//   - Transfer occurs when valid&&ready.
//   - out_* fields stay stable while out_valid&&!out_ready.
//   - Latency is 1 cycle from accept to out_valid.
//  SKID=0: in_ready = !out_valid || out_ready.
//  SKID=1: main + skid register.
//   - If out stalls while in_ready=1, the incoming instruction lands in skid.
//   - in_ready deasserts the next cycle; skid drains to main on the next out transfer.
//  Order: instructions leave in strict acceptance order; none dropped or duplicated.
//  flush:
//   - Next edge clears out_valid and skid.
//   - A same-cycle in_valid is dropped (flush wins).
//   - in_ready=1 on the cycle after flush.
//  Immediates:
//   - I/LOAD/JALR: sext(inst[31:20]).
//   - Shift-imm (funct3 001/101): zero-ext shamt inst[24:20] (XLEN=64: inst[25:20]).
//   - S: sext({inst[31:25],inst[11:7]}).
//   - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
//   - U: sext({inst[31:12],12'b0}).
//   - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
//   - R: imm=0.
//  Register-use flags:
//   - use_rs1 for R/I/LOAD/STORE/BRANCH/JALR.
//   - use_rs2 for R/STORE/BRANCH.
//   - wr_rd for R/I/LOAD/JALR/JAL/LUI/AUIPC, cleared when rd==0.
//  out_illegal=1 when any of the following holds:
//   - inst[1:0]!=2'b11.
//   - Unknown opcode.
//   - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101.
//   - SLLI funct7!=0, or SRLI/SRAI funct7 not 0x00/0x20.
//   - Branch funct3 010/011.
//   - Load funct3 011/110/111.
//   - Store funct3 >=011.
//   - JALR funct3!=000.
//  Illegal instructions still flow through with use/wr flags forced 0; they never stall.
//  Reset mid-stream: every held instruction is lost; there is no partial output.
// STRUCTURE
//  Package rv_decode_pkg:
//   - Opcode localparams OP_R3, OP_IMM, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
//   - enum imm_type_e {IMM_NONE,IMM_I,IMM_SH,IMM_S,IMM_B,IMM_U,IMM_J}.
//   - struct decoded_t (every out_* except valid), parameterised by XLEN via pkg-level typedef.
//  Sub-module rv_imm_gen (combinational: inst, imm_type -> XLEN imm).
//  This top: combinational field decode + illegal check, then main/skid decoded_t registers.
// TESTING
//  1 ADDI x1,x2,-1 (0xFFF10093) -> next cycle out_imm=0xFFFFFFFF, rd=1, rs1=2, use_rs1=1, wr_rd=1, illegal=0.
//  2 BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, use_rs1=use_rs2=1, wr_rd=0, rd=0; LUI x5 (0x123452B7) -> imm=0x12345000.
//  3 inst=0x00000000 and 0xFFFFFFFF -> out_illegal=1, all flags 0, out_valid=1 with no stall.
//  4 SKID=1: stream 4 insts with out_ready=0 for cycles 2-4 -> in_ready drops after 2 held, all 4 emerge in order, pc intact.
//  5 flush asserted with in_valid=1 and a stalled valid output -> next cycle out_valid=0, in_ready=1, no old pc ever appears.
//  6 rst_n pulsed low mid-stream (async, between edges) -> outputs zero immediately; first post-reset inst decodes correctly.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared opcode constants, immediate-format selector and decoded control bundle
// for the RV32I/RV64I decode stage.
package rv_decode_pkg;

    localparam logic [6:0] OP_R3    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SH,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // Width-independent part of the decoded bundle; pc and imm are sized by the stage.
    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       use_rs1;
        logic       use_rs2;
        logic       wr_rd;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: selects the instruction format and
// produces the immediate sign- (or zero-, for shift amounts) extended to XLEN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:  imm = XLEN'($signed(inst[31:20]));
            IMM_SH: begin
                if (XLEN == 64) imm = XLEN'(inst[25:20]);
                else            imm = XLEN'(inst[24:20]);
            end
            IMM_S:  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:  imm = XLEN'($signed({inst[31:12], 12'b0}));
            IMM_J:  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV64I decode stage: combinational field decode and illegal
// check feeding a valid/ready output register, optionally backed by a skid entry.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_use_rs1,
    output logic            out_use_rs2,
    output logic            out_wr_rd,
    output logic            out_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        decoded_t        dec;
    } stage_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd_field;
    imm_type_e       imm_type;
    logic [XLEN-1:0] imm;
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            wr_rd;
    logic            keep_f3;
    logic            keep_f7;
    logic            wr_eff;
    stage_t          d;
    stage_t          main_q;
    logic            main_valid;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rd_field = in_inst[11:7];

    always_comb begin
        imm_type = IMM_NONE;
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        wr_rd    = 1'b0;
        keep_f3  = 1'b1;
        keep_f7  = 1'b0;
        if (in_inst[1:0] == 2'b11) begin
            case (opcode)
                OP_R3: begin
                    legal   = (funct7 == 7'h00) ||
                              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    wr_rd   = 1'b1;
                    keep_f7 = 1'b1;
                end
                OP_IMM: begin
                    use_rs1 = 1'b1;
                    wr_rd   = 1'b1;
                    if (funct3 == 3'b001) begin
                        imm_type = IMM_SH;
                        keep_f7  = 1'b1;
                        legal    = (funct7 == 7'h00);
                    end else if (funct3 == 3'b101) begin
                        imm_type = IMM_SH;
                        keep_f7  = 1'b1;
                        legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end else begin
                        imm_type = IMM_I;
                        legal    = 1'b1;
                    end
                end
                OP_LD: begin
                    imm_type = IMM_I;
                    legal    = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
                    use_rs1  = 1'b1;
                    wr_rd    = 1'b1;
                end
                OP_ST: begin
                    imm_type = IMM_S;
                    legal    = (funct3 < 3'b011);
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                end
                OP_BR: begin
                    imm_type = IMM_B;
                    legal    = !(funct3 == 3'b010 || funct3 == 3'b011);
                    use_rs1  = 1'b1;
                    use_rs2  = 1'b1;
                end
                OP_JAL: begin
                    imm_type = IMM_J;
                    legal    = 1'b1;
                    wr_rd    = 1'b1;
                    keep_f3  = 1'b0;
                end
                OP_JALR: begin
                    imm_type = IMM_I;
                    legal    = (funct3 == 3'b000);
                    use_rs1  = 1'b1;
                    wr_rd    = 1'b1;
                end
                OP_LUI, OP_AUIPC: begin
                    imm_type = IMM_U;
                    legal    = 1'b1;
                    wr_rd    = 1'b1;
                    keep_f3  = 1'b0;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst     (in_inst[31:7]),
        .imm_type (imm_type),
        .imm      (imm)
    );

    // Illegal instructions keep their raw fields but never claim a register.
    assign wr_eff = legal && wr_rd && (rd_field != 5'd0);

    always_comb begin
        d                = '0;
        d.pc             = in_pc;
        d.imm            = imm;
        d.dec.op         = opcode;
        d.dec.use_rs1    = legal && use_rs1;
        d.dec.use_rs2    = legal && use_rs2;
        d.dec.wr_rd      = wr_eff;
        d.dec.illegal    = !legal;
        d.dec.rd         = wr_eff ? rd_field : 5'd0;
        d.dec.rs1        = (legal && use_rs1) ? in_inst[19:15] : 5'd0;
        d.dec.rs2        = (legal && use_rs2) ? in_inst[24:20] : 5'd0;
        d.dec.funct3     = keep_f3 ? funct3 : 3'd0;
        d.dec.funct7     = keep_f7 ? funct7 : 7'd0;
    end

    generate
        if (SKID != 0) begin : g_skid
            stage_t skid_q;
            logic   skid_valid;

            assign in_ready = !skid_valid;

            // A stalled main entry diverts the accepted word into skid; skid refills main first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_q     <= '0;
                    skid_valid <= 1'b0;
                    skid_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (!main_valid || out_ready) begin
                    if (skid_valid) begin
                        main_q     <= skid_q;
                        main_valid <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        main_valid <= in_valid;
                        if (in_valid) main_q <= d;
                    end
                end else if (in_valid && !skid_valid) begin
                    skid_q     <= d;
                    skid_valid <= 1'b1;
                end
            end
        end else begin : g_noskid
            assign in_ready = !main_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (in_ready) begin
                    main_valid <= in_valid;
                    if (in_valid) main_q <= d;
                end
            end
        end
    endgenerate

    assign out_valid   = main_valid;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_op      = main_q.dec.op;
    assign out_rd      = main_q.dec.rd;
    assign out_rs1     = main_q.dec.rs1;
    assign out_rs2     = main_q.dec.rs2;
    assign out_funct3  = main_q.dec.funct3;
    assign out_funct7  = main_q.dec.funct7;
    assign out_use_rs1 = main_q.dec.use_rs1;
    assign out_use_rs2 = main_q.dec.use_rs2;
    assign out_wr_rd   = main_q.dec.wr_rd;
    assign out_illegal = main_q.dec.illegal;

endmodule
